// File: rtl/bcd_pkg.sv
// Shared constants for the BCD up/down counter slice.
//   BCD_W        : bits per BCD digit
//   SEG_0..SEG_9 : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments off (used for non-decimal codes)
//   bcd_sat()    : clamps a nibble to a legal BCD digit (>9 becomes 9)
package bcd_pkg;
    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter.
//   master : drives enable, dir, oneshot, load, load_val; observes bcd, tc, done, seg
//   slave  : the counter itself
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2
);
    logic                  enable;
    logic                  dir;
    logic                  oneshot;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tc;
    logic                  done;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output enable, dir, oneshot, load, load_val,
        input  bcd, tc, done, seg
    );

    modport slave (
        input  enable, dir, oneshot, load, load_val,
        output bcd, tc, done, seg
    );
endinterface

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern {g..a}.
//   digit : 4-bit BCD code
//   seg   : segment pattern, blank for codes above 9
module seg7_decoder
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [6:0]       seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaler, wrap or one-shot stop,
// synchronous load and optional seven-segment output.
//   CLOCK_50 : clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : bcd_updown_counter_if.slave (enable, dir, oneshot, load,
//              load_val in; bcd, tc, done, seg out)
// Macro BCD_SEG_DECODE_EN: when defined, one seg7_decoder per digit drives
// seg; otherwise seg is tied to all-ones.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    bcd_updown_counter_if.slave bus
);
    localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]                    presc;
    logic [DIGITS-1:0][BCD_W-1:0]     cnt, cnt_nxt, ld_sat, term;
    logic                             tick, at_term, nxt_term, carry;
    logic                             tc_q, done_q;

    assign tick = bus.enable && (presc == PMAX);

    // Decimal step with ripple carry/borrow; all-9s+1 and all-0s-1 wrap naturally.
    always_comb begin
        cnt_nxt = cnt;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            term[i] = bus.dir ? 4'd9 : 4'd0;
            if (carry) begin
                if (bus.dir) begin
                    if (cnt[i] == 4'd9) cnt_nxt[i] = 4'd0;
                    else begin
                        cnt_nxt[i] = cnt[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end else begin
                    if (cnt[i] == 4'd0) cnt_nxt[i] = 4'd9;
                    else begin
                        cnt_nxt[i] = cnt[i] - 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
        end
    end

    assign at_term  = (cnt == term);
    assign nxt_term = (cnt_nxt == term);

    for (genvar g = 0; g < DIGITS; g++) begin : g_ld
        assign ld_sat[g] = bcd_sat(bus.load_val[g*4 +: 4]);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            cnt    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                cnt    <= ld_sat;
                presc  <= '0;
                done_q <= 1'b0;
            end else if (bus.enable) begin
                presc <= (presc == PMAX) ? '0 : presc + PW'(1);
                if (tick && !done_q) begin
                    if (bus.oneshot) begin
                        // Already sitting at the terminal: hold without pulsing.
                        if (!at_term) begin
                            cnt <= cnt_nxt;
                            if (nxt_term) begin
                                tc_q   <= 1'b1;
                                done_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt  <= cnt_nxt;
                        tc_q <= at_term;
                    end
                end
            end
        end
    end

    assign bus.bcd  = cnt;
    assign bus.tc   = tc_q;
    assign bus.done = done_q;

`ifdef BCD_SEG_DECODE_EN
    logic [DIGITS-1:0][6:0] seg_w;
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decoder u_seg (
            .digit (cnt[g]),
            .seg   (seg_w[g])
        );
    end
    assign bus.seg = seg_w;
`else
    assign bus.seg = '1;
`endif
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter, DIGITS=2, TICK_DIV=4.
module tb_bcd_updown_counter;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_updown_counter_if #(.DIGITS(2)) bus ();

    bcd_updown_counter #(
        .DIGITS   (2),
        .TICK_DIV (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        logic       en, dir, os, ld;
        logic [7:0] lv;
        int         n;
        logic [7:0] eb;
        logic       etc, edone;
    } vec_t;

    vec_t tv[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef BCD_SEG_DECODE_EN
    localparam logic [13:0] SEG00 = 14'b1000000_1000000;
    localparam logic [13:0] SEG37 = 14'b0110000_1111000;
`else
    localparam logic [13:0] SEG00 = 14'h3fff;
    localparam logic [13:0] SEG37 = 14'h3fff;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, dir, os, ld, input logic [7:0] lv,
                       input int n, input logic [7:0] eb, input logic etc, edone);
        vec_t v;
        v.en = en; v.dir = dir; v.os = os; v.ld = ld; v.lv = lv;
        v.n = n; v.eb = eb; v.etc = etc; v.edone = edone;
        tv.push_back(v);
    endtask

    task automatic drive(input logic en, dir, os, ld, input logic [7:0] lv);
        bus.enable = en; bus.dir = dir; bus.oneshot = os; bus.load = ld; bus.load_val = lv;
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        drive(0, 1, 0, 0, 8'h00);
        //  en dir os ld  lv     n   bcd   tc done
        add(1, 1, 0, 0, 8'h00,  4, 8'h01, 0, 0);  // first tick after 4 cycles
        add(1, 1, 0, 0, 8'h00, 36, 8'h10, 0, 0);  // 09->10 carry, no tc
        add(1, 1, 0, 1, 8'h99,  1, 8'h99, 0, 0);
        add(1, 1, 0, 0, 8'h00,  4, 8'h00, 1, 0);  // wrap up, tc pulse
        add(1, 1, 0, 0, 8'h00,  1, 8'h00, 0, 0);  // tc only one cycle
        add(1, 0, 1, 1, 8'h00,  1, 8'h00, 0, 0);
        add(1, 0, 1, 0, 8'h00,  4, 8'h00, 0, 0);  // already terminal: hold
        add(1, 0, 1, 1, 8'h02,  1, 8'h02, 0, 0);
        add(1, 0, 1, 0, 8'h00,  4, 8'h01, 0, 0);
        add(1, 0, 1, 0, 8'h00,  4, 8'h00, 1, 1);  // reach terminal: tc + done
        add(1, 0, 1, 0, 8'h00,  1, 8'h00, 0, 1);
        add(1, 0, 1, 0, 8'h00,  8, 8'h00, 0, 1);  // later ticks hold
        add(1, 1, 1, 0, 8'h00,  8, 8'h00, 0, 1);  // dir change while done
        add(1, 1, 0, 1, 8'h5C,  1, 8'h59, 0, 0);  // saturating load clears done
        add(1, 1, 0, 0, 8'h00,  3, 8'h59, 0, 0);  // prescaler at TICK_DIV-1
        add(1, 1, 0, 1, 8'h5C,  1, 8'h59, 0, 0);  // load beats tick
        add(1, 1, 0, 0, 8'h00,  3, 8'h59, 0, 0);  // prescaler restarted
        add(1, 1, 0, 0, 8'h00,  1, 8'h60, 0, 0);
        add(1, 1, 0, 0, 8'h00,  2, 8'h60, 0, 0);
        add(0, 1, 0, 0, 8'h00, 10, 8'h60, 0, 0);  // paused
        add(1, 1, 0, 0, 8'h00,  1, 8'h60, 0, 0);  // phase was held at 2
        add(1, 1, 0, 0, 8'h00,  1, 8'h61, 0, 0);
        add(1, 0, 0, 1, 8'h00,  1, 8'h00, 0, 0);
        add(1, 0, 0, 0, 8'h00,  4, 8'h99, 1, 0);  // wrap down
        add(1, 0, 0, 0, 8'h00,  4, 8'h98, 0, 0);
        add(1, 0, 0, 1, 8'hA3,  1, 8'h93, 0, 0);
        add(1, 1, 1, 1, 8'h98,  1, 8'h98, 0, 0);
        add(1, 1, 1, 0, 8'h00,  4, 8'h99, 1, 1);  // oneshot up stop
        add(1, 1, 1, 0, 8'h00,  4, 8'h99, 0, 1);
        add(0, 1, 0, 1, 8'h37,  1, 8'h37, 0, 0);  // load while disabled

        // reset state
        waitn(3);
        chk("rst_bcd",  bus.bcd,  8'h00);
        chk("rst_tc",   bus.tc,   1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("seg_00",   bus.seg,  SEG00);
        reset = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].en, tv[i].dir, tv[i].os, tv[i].ld, tv[i].lv);
            waitn(tv[i].n);
            chk($sformatf("v%0d_bcd", i),  bus.bcd,  tv[i].eb);
            chk($sformatf("v%0d_tc", i),   bus.tc,   tv[i].etc);
            chk($sformatf("v%0d_done", i), bus.done, tv[i].edone);
        end
        chk("seg_37", bus.seg, SEG37);

        // asynchronous reset mid-count, overriding load and enable
        drive(1, 1, 0, 0, 8'h00);
        waitn(2);
        #2;
        reset = 1'b0;
        drive(1, 1, 0, 1, 8'h55);
        #1;
        chk("arst_bcd",  bus.bcd,  8'h00);
        chk("arst_done", bus.done, 1'b0);
        waitn(2);
        chk("arst_hold", bus.bcd, 8'h00);
        reset = 1'b1;
        drive(1, 1, 0, 0, 8'h00);
        waitn(3);
        chk("rel_pre", bus.bcd, 8'h00);
        waitn(1);
        chk("rel_tick", bus.bcd, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DIGITS, 2, number of BCD digits, 1..8
  TICK_DIV, 50000000, CLOCK_50 cycles per count step, >=1
REQ-002 Ports SHALL be (name, direction, width, meaning):
  CLOCK_50  in  1  single clock, all logic on rising edge
  reset  in  1  asynchronous, active-low reset
  enable  in  1  1 = prescaler and counting run; 0 = pause, prescaler phase held
  dir  in  1  1 = count up; 0 = count down
  oneshot  in  1  1 = stop at terminal value; 0 = wrap
  load  in  1  synchronous load strobe
  load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
  bcd  out  4*DIGITS  current count, digit 0 in bits [3:0]
  tc  out  1  one-cycle terminal-count pulse
  done  out  1  sticky: oneshot stop reached
  seg  out  7*DIGITS  active-low segments {g..a} per digit (see REQ-019)

Function
REQ-003 Prescaler SHALL count 0..TICK_DIV-1 while enable=1, wrap to 0, and raise internal tick for the one cycle in which it equals TICK_DIV-1.
REQ-004 With enable=0 the prescaler and bcd SHALL hold; tick SHALL NOT assert.
REQ-005 On a tick with dir=1, bcd SHALL increment by one in decimal, carry rippling digit 0 upward, and update in the same clock edge as the tick (one-edge latency).
REQ-006 On a tick with dir=0, bcd SHALL decrement by one in decimal, borrow rippling upward; a digit at 0 becomes 9 on borrow.
REQ-007 Terminal value SHALL be all-9s when counting up and all-0s when counting down.
REQ-008 oneshot=0: a tick at terminal SHALL wrap (all-9s -> all-0s up; all-0s -> all-9s down) and assert tc for exactly the cycle following that edge, coincident with the wrapped value.
REQ-009 oneshot=1: a tick that makes bcd equal to the terminal SHALL assert tc for one cycle and set done; further ticks SHALL leave bcd unchanged and not pulse tc.
REQ-010 done SHALL clear only on reset or load; a change of dir while done=1 SHALL leave bcd held until load.
REQ-011 load=1 SHALL on that edge copy load_val to bcd, clear prescaler to 0, clear done, and suppress tc, regardless of enable.
REQ-012 Any load_val digit >9 SHALL be loaded as 9.
REQ-013 Simultaneous load and tick: load SHALL win; no count step occurs.
REQ-014 bcd digits SHALL never hold a value >9.

Reset
REQ-015 reset=0 SHALL asynchronously force bcd=0, prescaler=0, tc=0, done=0, independent of CLOCK_50.
REQ-016 Reset deassertion mid-count SHALL restart prescaler from 0; first tick occurs TICK_DIV enabled cycles later.
REQ-017 reset SHALL override load and enable.

Configuration
REQ-018 Macro BCD_SEG_DECODE_EN SHALL select seven-segment output generation.
REQ-019 With BCD_SEG_DECODE_EN defined, seg SHALL carry per-digit active-low patterns (0 = 1000000 ... 9 = 0010000, others 1111111) combinationally from bcd; without it, seg SHALL be tied to all-ones and no decoder instantiated.

Structure
REQ-020 Shared package bcd_pkg SHALL hold the 7-bit segment constants SEG_0..SEG_9, SEG_BLANK, and the BCD digit width constant.
REQ-021 One sub-module seg7_decoder (4-bit in, 7-bit active-low out) SHALL be instantiated DIGITS times under the macro.

Verification (TICK_DIV=4, DIGITS=2, macro defined)
REQ-022 reset low, then high, enable=1, dir=1 -> bcd 00, 01 after 4 cycles, 09 -> 10 carry after 40 cycles, tc stays 0.
REQ-023 load 99, dir=1, oneshot=0 -> next tick bcd=00, tc high exactly one cycle.
REQ-024 load 00, dir=0, oneshot=1 -> first tick bcd=99 wrap? No: bcd stays 00 when already terminal, then load 02 -> 01, 00 with tc pulse and done=1, later ticks hold 00.
REQ-025 load asserted on tick cycle with load_val=0x5C -> bcd=59, prescaler restarts, no tc.
REQ-026 enable=0 for 10 cycles mid-count -> bcd and prescaler phase frozen; resume completes step after remaining cycles.
REQ-027 bcd=37 -> seg = {SEG_3, SEG_7} = {0110000, 1111000}; without macro seg all ones.
